// File: rtl/reg_dump_reader.sv
// Debug-side register dump engine: walks an inclusive (wrapping) address range on the
// reg_file debug port and streams each word over valid/ready with a running XOR checksum.
module reg_dump_reader #(
  parameter int unsigned addr_size = 5,
  parameter int unsigned word      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [addr_size-1:0] first_addr,
  input  logic [addr_size-1:0] last_addr,
  output logic [addr_size-1:0] reg_num,
  input  logic [word-1:0]      reg_tmp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [word-1:0]      out_data,
  output logic [addr_size-1:0] out_index,
  output logic                 busy,
  output logic                 done,
  output logic [word-1:0]      checksum
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  state_e                 state_q, state_d;
  logic [addr_size-1:0]   cur_q, cur_d;
  logic [addr_size-1:0]   last_q, last_d;
  logic [addr_size-1:0]   reg_num_q, reg_num_d;
  logic                   out_valid_q, out_valid_d;
  logic [word-1:0]        out_data_q, out_data_d;
  logic [addr_size-1:0]   out_index_q, out_index_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [word-1:0]        checksum_q, checksum_d;
  logic [addr_size-1:0]   cur_inc;

  // Natural overflow of the address width gives the modulo-2**addr_size wrap.
  assign cur_inc = cur_q + addr_size'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      last_q      <= '0;
      reg_num_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      reg_num_q   <= reg_num_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    reg_num_d   = reg_num_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;

    if (abort) begin
      // Abort wins over start and over a coincident handshake; checksum keeps partial value.
      state_d     = StIdle;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_d      = first_addr;
            last_d     = last_addr;
            reg_num_d  = first_addr;
            checksum_d = '0;
            busy_d     = 1'b1;
            state_d    = StFetch;
          end
        end
        StFetch: begin
          out_data_d  = reg_tmp;
          out_index_d = cur_q;
          out_valid_d = 1'b1;
          state_d     = StSend;
        end
        StSend: begin
          if (out_ready) begin
            checksum_d  = checksum_q ^ out_data_q;
            out_valid_d = 1'b0;
            if (cur_q == last_q) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              cur_d     = cur_inc;
              reg_num_d = cur_inc;
              state_d   = StFetch;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign reg_num   = reg_num_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected words are queued when a dump is issued
// and popped by a negedge monitor on every handshake.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [4:0]  first_addr, last_addr, reg_num, out_index;
  logic [31:0] reg_tmp, out_data, checksum;
  logic        out_valid, busy, done;

  logic [31:0] regs [32];
  assign reg_tmp = regs[reg_num];

  reg_dump_reader #(.addr_size(5), .word(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .reg_num    (reg_num),
    .reg_tmp    (reg_tmp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_sum;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a handshake happens at the next posedge when valid&ready are up and no abort.
  logic        prev_hold;
  logic [31:0] prev_data;
  logic [4:0]  prev_index, prev_reg_num;
  initial prev_hold = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && prev_hold && out_valid) begin
      check("hold_data", out_data, prev_data);
      check("hold_index", out_index, prev_index);
      check("hold_reg_num", reg_num, prev_reg_num);
    end
    if (!reset && !abort && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got index %0d data 0x%0h, expected none", out_index,
                 out_data);
      end else begin
        e = sb.pop_front();
        check("out_index", out_index, e.idx);
        check("out_data", out_data, e.data);
        exp_sum = exp_sum ^ e.data;
      end
    end
    prev_hold    = !reset && !abort && out_valid === 1'b1 && !out_ready;
    prev_data    = out_data;
    prev_index   = out_index;
    prev_reg_num = reg_num;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  endtask

  // Model: the dump covers first, first+1, ... mod 32 up to and including last.
  task automatic issue(input logic [4:0] f, input logic [4:0] l, output int nwords);
    logic [4:0] idx;
    nwords = int'(5'(l - f)) + 1;
    idx = f;
    for (int i = 0; i < nwords; i++) begin
      sb.push_back('{idx: idx, data: regs[idx]});
      idx = idx + 5'd1;
    end
    exp_sum    = 32'h0;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cycles);
    cycles = c0;
    while (done !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("checksum_model", checksum, exp_sum);
    check("words_missing", sb.size(), 0);
    tick();
    check("done_pulse_width", done, 1'b0);
  endtask

  task automatic wait_word(input logic [4:0] idx, inout int c);
    int lim;
    lim = c + 100;
    while (!(out_valid === 1'b1 && out_index == idx) && c < lim) begin
      tick();
      c++;
    end
    check("reach_word", {out_valid, out_index}, {1'b1, idx});
  endtask

  initial begin
    int n, c;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_reg_num", reg_num, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    reset = 1'b0;
    tick();

    // 1: short range, ready high, latency and spacing
    out_ready = 1'b1;
    issue(5'd3, 5'd5, n);
    check("t1_busy", busy, 1);
    check("t1_valid_not_yet", out_valid, 0);
    check("t1_reg_num", reg_num, 3);
    tick();
    check("t1_first_valid", {out_valid, out_index}, {1'b1, 5'd3});
    wait_done(1, c);
    check("t1_cycles", c, 2 * n);
    check("t1_checksum", checksum, 32'h2);

    // 2: full range
    for (int i = 0; i < 32; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
    issue(5'd0, 5'd31, n);
    wait_done(0, c);
    check("t2_words", n, 32);
    check("t2_cycles", c, 64);
    check("t2_checksum", checksum, 32'h0);

    // 3: wrap-around
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    issue(5'd30, 5'd1, n);
    wait_done(0, c);
    check("t3_cycles", c, 8);
    check("t3_checksum", checksum, 32'h0);

    // 4: backpressure for 5 cycles on word 12
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    issue(5'd10, 5'd14, n);
    c = 0;
    wait_word(5'd12, c);
    out_ready = 1'b0;
    repeat (5) tick();
    check("t4_stall_reg_num", reg_num, 12);
    check("t4_stall_index", out_index, 12);
    out_ready = 1'b1;
    wait_done(c + 5, c);
    check("t4_cycles", c, 2 * n + 5);

    // 5: abort coincident with handshake of word 4
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    issue(5'd3, 5'd5, n);
    c = 0;
    wait_word(5'd4, c);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_valid_off", out_valid, 0);
    check("t5_busy_off", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_done", done, 0);
      tick();
    end
    check("t5_checksum", checksum, 32'h3);
    check("t5_checksum_model", checksum, exp_sum);
    sb.delete();
    // restart; a second start mid-dump must be ignored
    rand_ready = 1'b1;
    issue(5'd6, 5'd9, n);
    tick();
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, c);
    check("t5_restart_busy", busy, 0);

    // random dumps against the model
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      issue(5'($urandom_range(31)), 5'($urandom_range(31)), n);
      wait_done(0, c);
    end
    rand_ready = 1'b0;

    // 6: async reset between clock edges mid-dump
    out_ready = 1'b1;
    issue(5'd0, 5'd31, n);
    repeat (7) tick();
    #1;
    reset = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_checksum", checksum, 0);
    check("t6_reg_num", reg_num, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_index", out_index, 0);
    tick();
    reset = 1'b0;
    sb.delete();
    check("t6_no_done_after", done, 0);
    tick();

    // recovery after reset
    issue(5'd7, 5'd8, n);
    wait_done(0, c);
    check("t6_recover_cycles", c, 4);
    check("t6_recover_checksum", checksum, regs[7] ^ regs[8]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
